// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the MIPS pipeline datapath and pipeline_ctrl.
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if #(
    parameter int REG_W = 5
);
    logic             ihit;
    logic             dhit;
    logic             dmem_req;
    logic             idex_dREN;
    logic [REG_W-1:0] idex_wsel;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_use_rt;
    logic             redirect;
    logic             halt_wb;
    logic             pc_en;
    logic [3:0]       stage_en;
    logic [3:0]       flush;
    logic             halt_out;
    logic [1:0]       state;

    modport master (
        output ihit, dhit, dmem_req, idex_dREN, idex_wsel,
        output ifid_rs, ifid_rt, ifid_use_rt, redirect, halt_wb,
        input  pc_en, stage_en, flush, halt_out, state
    );

    modport slave (
        input  ihit, dhit, dmem_req, idex_dREN, idex_wsel,
        input  ifid_rs, ifid_rt, ifid_use_rt, redirect, halt_wb,
        output pc_en, stage_en, flush, halt_out, state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 4-register MIPS pipeline.
// Define PIPE_PERF_CNT_EN to add saturating stall_cnt/flush_cnt counters.
module pipeline_ctrl #(
    parameter int REG_W = 5
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    pipeline_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_halt;
    logic [REG_W-1:0] w_wsel;
    logic             w_mem_wait;
    logic             w_load_use;
    logic             w_halted;

    assign w_wsel     = bus.idex_wsel;
    assign w_mem_wait = bus.dmem_req & ~bus.dhit;
    assign w_halted   = (r_state == HALTED);
    assign w_load_use = bus.idex_dREN & (w_wsel != '0) &
                        ((w_wsel == bus.ifid_rs) |
                         (bus.ifid_use_rt & (w_wsel == bus.ifid_rt)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_halt  <= (w_next == HALTED);
        end
    end

    // halt_wb only changes the next state; this cycle's outputs stay as RUN
    always_comb begin
        w_next = RUN;
        if (w_halted)
            w_next = HALTED;
        else if (bus.halt_wb)
            w_next = HALTED;
        else if (w_mem_wait)
            w_next = MEMWAIT;
        else if (bus.redirect)
            w_next = RUN;
        else if (w_load_use)
            w_next = LDSTALL;
    end

    always_comb begin
        bus.pc_en    = 1'b0;
        bus.stage_en = 4'b0000;
        bus.flush    = 4'b0000;
        if (RST) begin
            bus.flush = 4'b1111;
        end else if (w_halted || w_mem_wait) begin
            bus.flush = 4'b0000;
        end else if (bus.redirect) begin
            bus.pc_en    = 1'b1;
            bus.stage_en = 4'b1111;
            bus.flush    = 4'b0111;
        end else if (w_load_use) begin
            bus.stage_en = 4'b1110;
            bus.flush    = 4'b0010;
        end else if (!bus.ihit) begin
            bus.stage_en = 4'b1111;
            bus.flush    = 4'b0001;
        end else begin
            bus.pc_en    = 1'b1;
            bus.stage_en = 4'b1111;
        end
    end

    assign bus.state    = r_state;
    assign bus.halt_out = r_halt;

`ifdef PIPE_PERF_CNT_EN
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_stall_inc = ~RST & ~w_halted & ~bus.pc_en;
    assign w_flush_inc = ~RST & ~w_halted & ~w_mem_wait & bus.redirect;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus
// randomized traffic against a behavioural priority model.
module tb_pipeline_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    int   m_state;
    bit   m_halt;
    int   m_stall;
    int   m_flush;

    pipeline_ctrl_if #(.REG_W(5)) bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;

    pipeline_ctrl #(.REG_W(5), .CNT_W(TB_CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    pipeline_ctrl #(.REG_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit mdl_load_use();
        if (!bus.idex_dREN || bus.idex_wsel == 5'd0)
            return 1'b0;
        if (bus.idex_wsel == bus.ifid_rs)
            return 1'b1;
        return bus.ifid_use_rt && (bus.idex_wsel == bus.ifid_rt);
    endfunction

    // {pc_en, stage_en, flush}
    function automatic logic [8:0] mdl_out();
        bit mw;
        mw = bus.dmem_req && !bus.dhit;
        if (RST) return {1'b0, 4'b0000, 4'b1111};
        if (m_state == 3 || mw) return 9'd0;
        if (bus.redirect) return {1'b1, 4'b1111, 4'b0111};
        if (mdl_load_use()) return {1'b0, 4'b1110, 4'b0010};
        if (!bus.ihit) return {1'b0, 4'b1111, 4'b0001};
        return {1'b1, 4'b1111, 4'b0000};
    endfunction

    function automatic int mdl_next();
        if (m_state == 3 || bus.halt_wb) return 3;
        if (bus.dmem_req && !bus.dhit) return 2;
        if (bus.redirect) return 0;
        if (mdl_load_use()) return 1;
        return 0;
    endfunction

    // advance one clock, keeping the model in step
    task automatic cycle();
        int         nxt;
        logic [8:0] o;
        bit         active;
        nxt    = mdl_next();
        o      = mdl_out();
        active = !RST && m_state != 3;
        @(posedge CLK);
        if (RST) begin
            m_state = 0;
            m_halt  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (active && !o[8])
                m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
            if (active && !(bus.dmem_req && !bus.dhit) && bus.redirect)
                m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            m_state = nxt;
            m_halt  = (nxt == 3);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.ihit        = 1'b1;
        bus.dhit        = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.idex_dREN   = 1'b0;
        bus.idex_wsel   = 5'd0;
        bus.ifid_rs     = 5'd0;
        bus.ifid_rt     = 5'd0;
        bus.ifid_use_rt = 1'b0;
        bus.redirect    = 1'b0;
        bus.halt_wb     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ihit = 1'b0;
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++;
            if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b0_0000_1111) begin
                failures++;
                $display("FAIL reset_out got=%b exp=0_0000_1111",
                         {bus.pc_en, bus.stage_en, bus.flush});
            end
            cycle();
        end
        RST = 1'b0;
        bus.ihit = 1'b1;
        #3;
        checks++;
        if ({bus.state, bus.halt_out} !== 3'b00_0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=000", {bus.state, bus.halt_out});
        end
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b1_1111_0000) begin
            failures++;
            $display("FAIL reset_run got=%b exp=1_1111_0000",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        cycle();
    endtask

    task automatic test_load_use();
        idle_inputs();
        bus.idex_dREN = 1'b1;
        bus.idex_wsel = 5'd5;
        bus.ifid_rs   = 5'd5;
        #3;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b0_1110_0010) begin
            failures++;
            $display("FAIL ldu_out got=%b exp=0_1110_0010",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        cycle();
        checks++;
        if (bus.state !== 2'd1) begin
            failures++;
            $display("FAIL ldu_state got=%0d exp=1", bus.state);
        end
        bus.ifid_rs     = 5'd9;
        bus.ifid_rt     = 5'd5;
        bus.ifid_use_rt = 1'b1;
        #1;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b0_1110_0010) begin
            failures++;
            $display("FAIL ldu_rt got=%b exp=0_1110_0010",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        bus.ifid_use_rt = 1'b0;
        #1;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b1_1111_0000) begin
            failures++;
            $display("FAIL ldu_rt_unused got=%b exp=1_1111_0000",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        cycle();
        bus.idex_wsel = 5'd0;
        bus.ifid_rs   = 5'd0;
        #3;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b1_1111_0000) begin
            failures++;
            $display("FAIL ldu_r0 got=%b exp=1_1111_0000",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        cycle();
        checks++;
        if (bus.state !== 2'd0) begin
            failures++;
            $display("FAIL ldu_r0_state got=%0d exp=0", bus.state);
        end
        idle_inputs();
    endtask

    task automatic test_memwait();
        idle_inputs();
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'd0) begin
                failures++;
                $display("FAIL mw_freeze[%0d] got=%b exp=0", i,
                         {bus.pc_en, bus.stage_en, bus.flush});
            end
            cycle();
            checks++;
            if (bus.state !== 2'd2) begin
                failures++;
                $display("FAIL mw_state[%0d] got=%0d exp=2", i, bus.state);
            end
        end
        bus.dhit = 1'b1;
        #3;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b1_1111_0000) begin
            failures++;
            $display("FAIL mw_release got=%b exp=1_1111_0000",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        cycle();
        checks++;
        if (bus.state !== 2'd0) begin
            failures++;
            $display("FAIL mw_exit got=%0d exp=0", bus.state);
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        idle_inputs();
        bus.redirect  = 1'b1;
        bus.ihit      = 1'b0;
        bus.idex_dREN = 1'b1;
        bus.idex_wsel = 5'd7;
        bus.ifid_rs   = 5'd7;
        #3;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush} !== 9'b1_1111_0111) begin
            failures++;
            $display("FAIL redir_out got=%b exp=1_1111_0111",
                     {bus.pc_en, bus.stage_en, bus.flush});
        end
        cycle();
        checks++;
        if (bus.state !== 2'd0) begin
            failures++;
            $display("FAIL redir_state got=%0d exp=0", bus.state);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        idle_inputs();
        bus.halt_wb = 1'b1;
        #3;
        checks++;
        if ({bus.pc_en, bus.stage_en, bus.flush, bus.halt_out} !== 10'b1_1111_0000_0) begin
            failures++;
            $display("FAIL halt_entry got=%b exp=1_1111_0000_0",
                     {bus.pc_en, bus.stage_en, bus.flush, bus.halt_out});
        end
        cycle();
        bus.halt_wb  = 1'b0;
        bus.redirect = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            checks++;
            if ({bus.halt_out, bus.state, bus.pc_en, bus.stage_en, bus.flush}
                !== 12'b1_11_0_0000_0000) begin
                failures++;
                $display("FAIL halt_hold[%0d] got=%b exp=1_11_0_0000_0000", i,
                         {bus.halt_out, bus.state, bus.pc_en, bus.stage_en, bus.flush});
            end
            cycle();
        end
        bus.redirect = 1'b0;
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        #3;
        checks++;
        if ({bus.state, bus.halt_out} !== 3'b00_0) begin
            failures++;
            $display("FAIL halt_exit got=%b exp=000", {bus.state, bus.halt_out});
        end
        cycle();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        idle_inputs();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        bus.ihit = 1'b0;
        repeat (3) cycle();
        bus.redirect = 1'b1;
        cycle();
        bus.redirect = 1'b0;
        bus.ihit     = 1'b1;
        #2;
        checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL perf_cnt got=%0d/%0d exp=3/1", stall_cnt, flush_cnt);
        end
        bus.ihit = 1'b0;
        repeat (CNT_MAX + 3) cycle();
        #2;
        checks++;
        if (stall_cnt !== 4'hF) begin
            failures++;
            $display("FAIL perf_sat got=%0d exp=15", stall_cnt);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        logic [8:0] exp;
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            RST             = ($urandom_range(0, 39) == 0);
            bus.halt_wb     = ($urandom_range(0, 29) == 0);
            bus.ihit        = ($urandom_range(0, 3) != 0);
            bus.dmem_req    = $urandom_range(0, 1);
            bus.dhit        = $urandom_range(0, 1);
            bus.redirect    = ($urandom_range(0, 5) == 0);
            bus.idex_dREN   = $urandom_range(0, 1);
            bus.idex_wsel   = 5'($urandom_range(0, 3));
            bus.ifid_rs     = 5'($urandom_range(0, 3));
            bus.ifid_rt     = 5'($urandom_range(0, 3));
            bus.ifid_use_rt = $urandom_range(0, 1);
            #2;
            exp = mdl_out();
            checks++;
            if ({bus.pc_en, bus.stage_en, bus.flush} !== exp) begin
                failures++;
                $display("FAIL rnd_out[%0d] got=%b exp=%b", n,
                         {bus.pc_en, bus.stage_en, bus.flush}, exp);
            end
            checks++;
            if (bus.state !== 2'(m_state) || bus.halt_out !== m_halt) begin
                failures++;
                $display("FAIL rnd_state[%0d] got=%0d/%b exp=%0d/%b", n,
                         bus.state, bus.halt_out, m_state, m_halt);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
                failures++;
                $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n,
                         stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
            cycle();
        end
        RST = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_state  = 0;
        m_halt   = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        RST      = 1'b1;
        idle_inputs();
        @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_memwait();
        test_redirect();
        test_halt();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
